mcpu_alu_pipe: RTL and testbench

- Pipelined, handshaked ALU responder for the MCPU datapath.
- Accepts opcode plus two operands from the issuing stage, computes AND/OR/XOR/ADD, and returns the result with a carry/overflow flag.
- Two register stages with valid/ready flow control in both directions; full backpressure from the consumer.
- Sits between the MCPU decode/issue logic (initiator) and the writeback stage.

---
 rtl/mcpu_alu_pkg.sv | 12 +
 rtl/mcpu_alu_pipe_if.sv | 26 ++
 rtl/mcpu_alu_core.sv | 31 +++
 rtl/mcpu_alu_pipe.sv | 111 +++++++++++
 tb/tb_mcpu_alu_pipe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_alu_pkg.sv
// Shared constants for the MCPU ALU: opcode encodings and default widths.
package mcpu_alu_pkg;

   localparam int unsigned DEF_CMD_SIZE  = 32'd2;
   localparam int unsigned DEF_WORD_SIZE = 32'd8;

   localparam logic [1:0] OP_AND = 2'd0;
   localparam logic [1:0] OP_OR  = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;
   localparam logic [1:0] OP_ADD = 2'd3;

endpackage

// File: rtl/mcpu_alu_pipe_if.sv
// Request/response bundle between the issue stage (master) and the ALU pipe (slave).
interface mcpu_alu_pipe_if #(
   parameter int CMD_SIZE  = 2,
   parameter int WORD_SIZE = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [CMD_SIZE-1:0]  opcode;
   logic [WORD_SIZE-1:0] r1;
   logic [WORD_SIZE-1:0] r2;
   logic                 out_valid;
   logic                 out_ready;
   logic [WORD_SIZE-1:0] out;
   logic                 OVERFLOW;
   logic                 idle;

   modport master (
      output in_valid, opcode, r1, r2, out_ready,
      input  in_ready, out_valid, out, OVERFLOW, idle
   );

   modport slave (
      input  in_valid, opcode, r1, r2, out_ready,
      output in_ready, out_valid, out, OVERFLOW, idle
   );
endinterface

// File: rtl/mcpu_alu_core.sv
// Combinational ALU compute of {carry, result}; shared with the single-cycle ALU.
module mcpu_alu_core
   import mcpu_alu_pkg::*;
#(
   parameter int CMD_SIZE  = DEF_CMD_SIZE,
   parameter int WORD_SIZE = DEF_WORD_SIZE
) (
   input  logic [CMD_SIZE-1:0]  i_opcode,
   input  logic [WORD_SIZE-1:0] i_r1,
   input  logic [WORD_SIZE-1:0] i_r2,
   output logic [WORD_SIZE-1:0] o_out,
   output logic                 o_ovf
);

   logic [WORD_SIZE:0] w_sum;

   assign w_sum = {1'b0, i_r1} + {1'b0, i_r2};

   // Opcode decode; every unlisted encoding falls through to ADD.
   always_comb begin
      o_out = w_sum[WORD_SIZE-1:0];
      o_ovf = 1'b0;
      case (i_opcode)
         CMD_SIZE'(OP_AND): o_out = i_r1 & i_r2;
         CMD_SIZE'(OP_OR):  o_out = i_r1 | i_r2;
         CMD_SIZE'(OP_XOR): o_out = i_r1 ^ i_r2;
         default:           {o_ovf, o_out} = w_sum;
      endcase
   end

endmodule

// File: rtl/mcpu_alu_pipe.sv
// Two-stage valid/ready ALU pipe. Define MCPU_ALU_STATS_EN for transfer/carry counters.
module mcpu_alu_pipe
   import mcpu_alu_pkg::*;
#(
   parameter int CMD_SIZE  = DEF_CMD_SIZE,
   parameter int WORD_SIZE = DEF_WORD_SIZE
) (
   input  logic              clk,
   input  logic              reset,
   mcpu_alu_pipe_if.slave    bus
`ifdef MCPU_ALU_STATS_EN
   ,
   output logic [15:0]       op_count,
   output logic [15:0]       ovf_count
`endif
);

   logic                 r_s1_valid;
   logic [CMD_SIZE-1:0]  r_s1_op;
   logic [WORD_SIZE-1:0] r_s1_a;
   logic [WORD_SIZE-1:0] r_s1_b;
   logic                 r_out_valid;
   logic [WORD_SIZE-1:0] r_out;
   logic                 r_ovf;

   logic                 w_adv2;
   logic                 w_s1_to_s2;
   logic                 w_in_xfer;
   logic [WORD_SIZE-1:0] w_res;
   logic                 w_res_ovf;

   assign w_adv2      = !r_out_valid || bus.out_ready;
   assign w_s1_to_s2  = r_s1_valid && w_adv2;
   assign bus.in_ready = !r_s1_valid || w_adv2;
   assign w_in_xfer   = bus.in_valid && bus.in_ready;

   // Stage 1: capture the request; empties when it moves on with nothing new behind it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
      end else if (w_in_xfer) begin
         r_s1_valid <= 1'b1;
         r_s1_op    <= bus.opcode;
         r_s1_a     <= bus.r1;
         r_s1_b     <= bus.r2;
      end else if (w_s1_to_s2) begin
         r_s1_valid <= 1'b0;
      end
   end

   mcpu_alu_core #(
      .CMD_SIZE  (CMD_SIZE),
      .WORD_SIZE (WORD_SIZE)
   ) u_core (
      .i_opcode (r_s1_op),
      .i_r1     (r_s1_a),
      .i_r2     (r_s1_b),
      .o_out    (w_res),
      .o_ovf    (w_res_ovf)
   );

   // Stage 2: result register; data is kept when it drains empty so out/OVERFLOW stay put.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_ovf       <= 1'b0;
      end else if (w_adv2) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out <= w_res;
            r_ovf <= w_res_ovf;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.OVERFLOW  = r_ovf;
   assign bus.idle      = !r_s1_valid && !r_out_valid;

`ifdef MCPU_ALU_STATS_EN
   logic [15:0] r_op_count;
   logic [15:0] r_ovf_count;
   logic        w_out_xfer;

   assign w_out_xfer = r_out_valid && bus.out_ready;

   // Saturating counters of completed results and of those carrying out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op_count  <= 16'd0;
         r_ovf_count <= 16'd0;
      end else if (w_out_xfer) begin
         if (r_op_count != 16'hFFFF) begin
            r_op_count <= r_op_count + 16'd1;
         end
         if (r_ovf && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
         end
      end
   end

   assign op_count  = r_op_count;
   assign ovf_count = r_ovf_count;
`endif

endmodule

// File: tb/tb_mcpu_alu_pipe.sv
// Self-checking bench for mcpu_alu_pipe against a capacity-2, min-latency-2 FIFO model.
module tb_mcpu_alu_pipe;

   logic clk;
   logic rst;

   mcpu_alu_pipe_if #(.CMD_SIZE(2), .WORD_SIZE(8)) bus();

`ifdef MCPU_ALU_STATS_EN
   logic [15:0] op_count;
   logic [15:0] ovf_count;
`endif

   mcpu_alu_pipe #(.CMD_SIZE(2), .WORD_SIZE(8)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
`ifdef MCPU_ALU_STATS_EN
      ,
      .op_count  (op_count),
      .ovf_count (ovf_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] res;
      logic       ovf;
      int         acc;
   } item_t;

   item_t       q[$];
   int          cyc;
   logic [7:0]  last_out;
   logic        last_ovf;
   logic [15:0] m_ops;
   logic [15:0] m_ovfs;
   int          total;
   int          bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic item_t alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      item_t it;
      int    s;
      it.ovf = 1'b0;
      it.acc = 0;
      case (op)
         2'd0:    it.res = a & b;
         2'd1:    it.res = a | b;
         2'd2:    it.res = a ^ b;
         default: begin
            s      = int'(a) + int'(b);
            it.res = s[7:0];
            it.ovf = (s > 255);
         end
      endcase
      return it;
   endfunction

   // One cycle: drive at negedge, check against the model, then advance the model at posedge.
   task automatic step(input logic iv, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ordy);
      logic  exp_valid;
      logic  exp_ready;
      item_t it;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.opcode    = op;
      bus.r1        = a;
      bus.r2        = b;
      bus.out_ready = ordy;
      #1;
      exp_valid = (q.size() > 0) && (q[0].acc + 1 < cyc);
      exp_ready = (q.size() < 2) || ordy;
      if (exp_valid) begin
         last_out = q[0].res;
         last_ovf = q[0].ovf;
      end
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("in_ready",  32'(bus.in_ready),  32'(exp_ready));
      chk("out",       32'(bus.out),       32'(last_out));
      chk("OVERFLOW",  32'(bus.OVERFLOW),  32'(last_ovf));
      chk("idle",      32'(bus.idle),      32'(q.size() == 0));
`ifdef MCPU_ALU_STATS_EN
      chk("op_count",  32'(op_count),  32'(m_ops));
      chk("ovf_count", 32'(ovf_count), 32'(m_ovfs));
`endif
      @(posedge clk);
      if (exp_valid && ordy) begin
         if (m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
         if (q[0].ovf && (m_ovfs != 16'hFFFF)) m_ovfs = m_ovfs + 16'd1;
         void'(q.pop_front());
      end
      if (iv && exp_ready) begin
         it     = alu_ref(op, a, b);
         it.acc = cyc;
         q.push_back(it);
      end
      cyc++;
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
   endtask

   // Asynchronous reset landing between edges with traffic in flight.
   task automatic reset_mid();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out",       32'(bus.out),       32'd0);
      chk("rst_ovf",       32'(bus.OVERFLOW),  32'd0);
      chk("rst_idle",      32'(bus.idle),      32'd1);
`ifdef MCPU_ALU_STATS_EN
      chk("rst_op_count",  32'(op_count),  32'd0);
      chk("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      last_out = 8'd0;
      last_ovf = 1'b0;
      m_ops    = 16'd0;
      m_ovfs   = 16'd0;
      #1;
      chk("post_rst_idle",     32'(bus.idle),     32'd1);
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      last_out = 8'd0;
      last_ovf = 1'b0;
      m_ops = 16'd0;
      m_ovfs = 16'd0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.opcode = 2'd0;
      bus.r1 = 8'd0;
      bus.r2 = 8'd0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("init_out_valid", 32'(bus.out_valid), 32'd0);
      chk("init_out",       32'(bus.out),       32'd0);
      chk("init_ovf",       32'(bus.OVERFLOW),  32'd0);
      chk("init_idle",      32'(bus.idle),      32'd1);
      chk("init_in_ready",  32'(bus.in_ready),  32'd1);

      // Single ops and ADD carry.
      step(1'b1, 2'd0, 8'd4,   8'd4,   1'b1);
      step(1'b1, 2'd1, 8'd4,   8'd0,   1'b1);
      step(1'b1, 2'd2, 8'd4,   8'd4,   1'b1);
      step(1'b1, 2'd3, 8'hFF,  8'h01,  1'b1);
      step(1'b1, 2'd3, 8'd4,   8'd4,   1'b1);
      drain(3);

      // Back-to-back streaming.
      for (int i = 0; i < 8; i++) step(1'b1, 2'd3, 8'(i), 8'(i), 1'b1);
      drain(3);

      // Backpressure: third request waits until the consumer releases.
      step(1'b1, 2'd3, 8'h10, 8'h01, 1'b0);
      step(1'b1, 2'd0, 8'hF0, 8'h3C, 1'b0);
      step(1'b1, 2'd1, 8'h05, 8'h0A, 1'b0);
      step(1'b1, 2'd1, 8'h05, 8'h0A, 1'b0);
      step(1'b1, 2'd1, 8'h05, 8'h0A, 1'b1);
      drain(4);

      // Reset with requests in flight, then a directed stats run.
      step(1'b1, 2'd3, 8'd1, 8'd1, 1'b1);
      step(1'b1, 2'd3, 8'd2, 8'd2, 1'b0);
      reset_mid();
      step(1'b1, 2'd3, 8'hFF, 8'h01, 1'b1);
      step(1'b1, 2'd3, 8'h80, 8'h80, 1'b1);
      step(1'b1, 2'd3, 8'd1,  8'd2,  1'b1);
      step(1'b1, 2'd3, 8'd3,  8'd4,  1'b1);
      step(1'b1, 2'd3, 8'd5,  8'd6,  1'b1);
      drain(3);
`ifdef MCPU_ALU_STATS_EN
      @(negedge clk);
      #1;
      chk("stats_op_count",  32'(op_count),  32'd5);
      chk("stats_ovf_count", 32'(ovf_count), 32'd2);
`endif
      reset_mid();

      // Randomized traffic with random consumer stalls.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              $urandom_range(0, 3) != 0);
      end
      drain(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
